rst_seq_gen: RTL and testbench

Reset sequencer that generates the per-domain active-low resets consumed by downstream clock/reset interfaces and their synchronizers. It holds every domain in reset until the PLL reports lock, enforces a minimum assertion width, then releases the domains one at a time in index order. It re-enters reset on loss of lock or on a software request. Sits at the top level between the board reset/PLL and the clock-domain reset inputs.

---
 rtl/rst_seq_gen.sv | 166 ++++++++++++++++
 tb/tb_rst_seq_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all domain resets until PLL lock, then releases them one at a time in index order.
// Define RST_SEQ_GEN_REVERSE_ASSERT_EN for a descending, gap-spaced shutdown on software request.
module rst_seq_gen #(
  parameter int NUM_DOMAINS       = 4,
  parameter int NO_OF_SYNC_STAGES = 2,
  parameter int HOLD_CYCLES       = 16,
  parameter int GAP_CYCLES        = 8
) (
  input  logic                   clk_ir,
  input  logic                   rst_async_il,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_seq_l_o,
  output logic                   rst_done_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] BIT0      = NUM_DOMAINS'(1);

`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
  localparam logic [IDX_W-1:0] IDX_SHUT_START = (NUM_DOMAINS > 1) ? IDX_W'(NUM_DOMAINS - 2) : '0;
  typedef enum logic [2:0] {WAIT_LOCK, HOLD, RELEASE, RUN, ASSERT_SEQ} state_t;
`else
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;
`endif

  logic [NO_OF_SYNC_STAGES-1:0] lock_sync_q;
  logic                         lock_s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_seq_q, rst_seq_d;
  logic                   done_q, done_d;

  // Lock synchronizer: pll_locked_i is asynchronous to clk_ir
  always_ff @(posedge clk_ir or negedge rst_async_il) begin
    if (!rst_async_il) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[NO_OF_SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign lock_s = lock_sync_q[NO_OF_SYNC_STAGES-1];

  always_ff @(posedge clk_ir or negedge rst_async_il) begin
    if (!rst_async_il) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_seq_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_seq_q <= rst_seq_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_seq_d = rst_seq_q;
    done_d    = done_q;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_seq_d = '0;
        done_d    = 1'b0;
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rst_seq_d[0] = 1'b1;
          idx_d        = IDX_W'(1);
          cnt_d        = '0;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          rst_seq_d = rst_seq_q | (BIT0 << idx_q);
          idx_d     = idx_q + IDX_W'(1);
          cnt_d     = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (sw_rst_req_i) begin
          done_d = 1'b0;
          cnt_d  = '0;
`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
          // Shutdown mirrors the release order: highest index drops first
          rst_seq_d = rst_seq_q & ~(BIT0 << (NUM_DOMAINS - 1));
          idx_d     = IDX_SHUT_START;
          state_d   = (NUM_DOMAINS == 1) ? HOLD : ASSERT_SEQ;
`else
          rst_seq_d = '0;
          state_d   = HOLD;
`endif
        end
      end

`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
      ASSERT_SEQ: begin
        if (cnt_q == GAP_LAST) begin
          rst_seq_d = rst_seq_q & ~(BIT0 << idx_q);
          cnt_d     = '0;
          if (idx_q == '0) begin
            state_d = HOLD;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Loss of lock outranks everything, including a same-cycle software request
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      idx_d     = '0;
      rst_seq_d = '0;
      done_d    = 1'b0;
    end
  end

  assign rst_seq_l_o = rst_seq_q;
  assign rst_done_o  = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed timing scenarios plus randomized lock/request traffic against a timeline model.
module tb_rst_seq_gen;

  localparam int N    = 4;
  localparam int NS   = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 8;

`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
  localparam int SHUT_LEN = (N - 1) * GAP + 1;
`else
  localparam int SHUT_LEN = 1;
`endif

  localparam int M_WAIT = 0;
  localparam int M_SEQ  = 1;
  localparam int M_SHUT = 2;

  logic         clk_ir       = 1'b0;
  logic         clk_run      = 1'b1;
  logic         rst_async_il = 1'b0;
  logic         pll_locked_i = 1'b0;
  logic         sw_rst_req_i = 1'b0;
  logic [N-1:0] rst_seq_l_o;
  logic         rst_done_o;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  int           m_mode;
  int           m_t;
  int           m_s;
  bit           lock_q[$];
  logic [N-1:0] exp_rst;
  logic         exp_done;

  rst_seq_gen #(
    .NUM_DOMAINS      (N),
    .NO_OF_SYNC_STAGES(NS),
    .HOLD_CYCLES      (HOLD),
    .GAP_CYCLES       (GAP)
  ) dut (
    .clk_ir      (clk_ir),
    .rst_async_il(rst_async_il),
    .pll_locked_i(pll_locked_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_seq_l_o (rst_seq_l_o),
    .rst_done_o  (rst_done_o)
  );

  always #5 if (clk_run) clk_ir = ~clk_ir;

  // Number of domains released t edges after the hold phase begins
  function automatic int released(input int t);
    int r;
    if (t < HOLD) return 0;
    r = 1 + (t - HOLD) / GAP;
    return (r > N) ? N : r;
  endfunction

  // Number of domains dropped s edges into a graceful shutdown (s=1 is the request edge)
  function automatic int fallen(input int s);
    int f;
    f = 1 + (s - 1) / GAP;
    return (f > N) ? N : f;
  endfunction

  task automatic model_reset();
    lock_q.delete();
    for (int i = 0; i < NS; i++) lock_q.push_back(1'b0);
    m_mode   = M_WAIT;
    m_t      = 0;
    m_s      = 0;
    exp_rst  = '0;
    exp_done = 1'b0;
  endtask

  task automatic model_update();
    bit lk;
    int r;
    if (!rst_async_il) begin
      model_reset();
      return;
    end
    lk = lock_q.pop_front();
    lock_q.push_back(pll_locked_i);
    if (m_mode != M_WAIT && !lk) begin
      m_mode = M_WAIT;
    end else begin
      case (m_mode)
        M_WAIT: if (lk) begin m_mode = M_SEQ; m_t = 0; end
        M_SEQ: begin
          if (released(m_t) == N && sw_rst_req_i) begin
`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
            m_mode = M_SHUT;
            m_s    = 1;
            if (fallen(m_s) >= N) begin m_mode = M_SEQ; m_t = 0; end
`else
            m_t = 0;
`endif
          end else begin
            m_t++;
          end
        end
        default: begin
          m_s++;
          if (fallen(m_s) >= N) begin m_mode = M_SEQ; m_t = 0; end
        end
      endcase
    end
    case (m_mode)
      M_WAIT: begin exp_rst = '0; exp_done = 1'b0; end
      M_SEQ: begin
        r        = released(m_t);
        exp_rst  = N'((32'd1 << r) - 32'd1);
        exp_done = (r == N);
      end
      default: begin
        exp_rst  = N'((32'd1 << (N - fallen(m_s))) - 32'd1);
        exp_done = 1'b0;
      end
    endcase
  endtask

  // One clock edge: the model sees the same inputs as the DUT, then we park on the falling edge
  task automatic tick();
    @(posedge clk_ir);
    model_update();
    @(negedge clk_ir);
    edge_no++;
  endtask

  task automatic test_reset();
    rst_async_il = 1'b0;
    pll_locked_i = 1'b1;
    sw_rst_req_i = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (rst_seq_l_o !== '0 || rst_done_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold k=%0d got rst=%b done=%b want rst=0 done=0", k, rst_seq_l_o, rst_done_o);
      end
    end
    pll_locked_i = 1'b0;
  endtask

  task automatic test_power_up();
    int first[N+1];
    int want;
    for (int i = 0; i <= N; i++) first[i] = -1;
    rst_async_il = 1'b1;
    repeat (4) tick();
    pll_locked_i = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        $display("FAIL pwrup_model k=%0d got rst=%b done=%b want rst=%b done=%b", k, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      for (int b = 0; b < N; b++) if (first[b] < 0 && rst_seq_l_o[b] === 1'b1) first[b] = k;
      if (first[N] < 0 && rst_done_o === 1'b1) first[N] = k;
    end
    for (int b = 0; b <= N; b++) begin
      want = NS + 1 + HOLD + ((b == N) ? N - 1 : b) * GAP;
      checks++;
      if (first[b] !== want) begin
        failures++;
        $display("FAIL pwrup_rise bit=%0d got edge %0d want edge %0d", b, first[b], want);
      end
    end
  endtask

  task automatic test_lock_loss();
    int found = 0;
    int rise0 = -1;
    pll_locked_i = 1'b0;
    repeat (6) tick();
    pll_locked_i = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (rst_seq_l_o === 4'b0011) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL lockloss_wait got rst=%b want 0011 within budget", rst_seq_l_o);
    end
    pll_locked_i = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        $display("FAIL lockloss_model k=%0d got rst=%b done=%b want rst=%b done=%b", k, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      if (k == 2) begin
        checks++;
        if (rst_seq_l_o !== 4'b0011) begin
          failures++;
          $display("FAIL lockloss_early got rst=%b want 0011", rst_seq_l_o);
        end
      end
      if (k == 3) begin
        checks++;
        if (rst_seq_l_o !== 4'b0000 || rst_done_o !== 1'b0) begin
          failures++;
          $display("FAIL lockloss_drop got rst=%b done=%b want 0000/0", rst_seq_l_o, rst_done_o);
        end
      end
      if (k == 10) pll_locked_i = 1'b1;
      if (k > 3 && rise0 < 0 && rst_seq_l_o[0] === 1'b1) rise0 = k;
    end
    checks++;
    if (rise0 !== 29) begin
      failures++;
      $display("FAIL relock_bit0 got edge %0d want edge 29", rise0);
    end
  endtask

  task automatic test_sw_rst();
    int found = 0;
    int fall[N];
    int rise0 = -1;
    int done_r = -1;
    logic [N-1:0] prev;
    logic prev_done;
    for (int b = 0; b < N; b++) fall[b] = -1;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (rst_done_o === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL swrst_wait got done=%b want 1 within budget", rst_done_o);
    end
    prev = rst_seq_l_o;
    prev_done = rst_done_o;
    sw_rst_req_i = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      sw_rst_req_i = 1'b0;
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        $display("FAIL swrst_model k=%0d got rst=%b done=%b want rst=%b done=%b", k, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      for (int b = 0; b < N; b++) if (fall[b] < 0 && prev[b] === 1'b1 && rst_seq_l_o[b] === 1'b0) fall[b] = k;
      if (fall[0] >= 0 && rise0 < 0 && prev[0] === 1'b0 && rst_seq_l_o[0] === 1'b1) rise0 = k;
      if (done_r < 0 && prev_done === 1'b0 && rst_done_o === 1'b1) done_r = k;
      prev = rst_seq_l_o;
      prev_done = rst_done_o;
    end
    for (int b = 0; b < N; b++) begin
`ifdef RST_SEQ_GEN_REVERSE_ASSERT_EN
      checks++;
      if (fall[b] !== 1 + (N - 1 - b) * GAP) begin
        failures++;
        $display("FAIL swrst_fall bit=%0d got edge %0d want edge %0d", b, fall[b], 1 + (N - 1 - b) * GAP);
      end
`else
      checks++;
      if (fall[b] !== 1) begin
        failures++;
        $display("FAIL swrst_fall bit=%0d got edge %0d want edge 1", b, fall[b]);
      end
`endif
    end
    checks++;
    if (rise0 !== SHUT_LEN + HOLD) begin
      failures++;
      $display("FAIL swrst_bit0 got edge %0d want edge %0d", rise0, SHUT_LEN + HOLD);
    end
    checks++;
    if (done_r !== SHUT_LEN + HOLD + (N - 1) * GAP) begin
      failures++;
      $display("FAIL swrst_done got edge %0d want edge %0d", done_r, SHUT_LEN + HOLD + (N - 1) * GAP);
    end
  endtask

  task automatic test_sw_ignored();
    int first[N];
    for (int b = 0; b < N; b++) first[b] = -1;
    pll_locked_i = 1'b0;
    repeat (6) tick();
    pll_locked_i = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      sw_rst_req_i = (k == 9 || k == 15 || k == 22 || k == 30 || k == 41);
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        $display("FAIL swign_model k=%0d got rst=%b done=%b want rst=%b done=%b", k, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      for (int b = 0; b < N; b++) if (first[b] < 0 && rst_seq_l_o[b] === 1'b1) first[b] = k;
    end
    sw_rst_req_i = 1'b0;
    for (int b = 0; b < N; b++) begin
      checks++;
      if (first[b] !== NS + 1 + HOLD + b * GAP) begin
        failures++;
        $display("FAIL swign_rise bit=%0d got edge %0d want edge %0d", b, first[b], NS + 1 + HOLD + b * GAP);
      end
    end
  endtask

  task automatic test_async_reset();
    int found = 0;
    int rise0 = -1;
    pll_locked_i = 1'b0;
    repeat (6) tick();
    pll_locked_i = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (rst_seq_l_o === 4'b0011) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL arst_wait got rst=%b want 0011 within budget", rst_seq_l_o);
    end
    clk_run = 1'b0;
    #7;
    rst_async_il = 1'b0;
    #1;
    checks++;
    if (rst_seq_l_o !== '0 || rst_done_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_noclk got rst=%b done=%b want 0000/0", rst_seq_l_o, rst_done_o);
    end
    model_reset();
    #6;
    rst_async_il = 1'b1;
    #3;
    clk_run = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        $display("FAIL arst_model k=%0d got rst=%b done=%b want rst=%b done=%b", k, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      if (rise0 < 0 && rst_seq_l_o[0] === 1'b1) rise0 = k;
    end
    checks++;
    if (rise0 !== 19) begin
      failures++;
      $display("FAIL arst_bit0 got edge %0d want edge 19", rise0);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 4000; k++) begin
      tick();
      checks++;
      if (rst_seq_l_o !== exp_rst || rst_done_o !== exp_done) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_model edge=%0d got rst=%b done=%b want rst=%b done=%b", edge_no, rst_seq_l_o, rst_done_o, exp_rst, exp_done);
      end
      if ($urandom_range(0, 119) == 0) pll_locked_i = ~pll_locked_i;
      if (!pll_locked_i && $urandom_range(0, 7) == 0) pll_locked_i = 1'b1;
      sw_rst_req_i = !sw_rst_req_i && ($urandom_range(0, 24) == 0);
    end
    sw_rst_req_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_lock_loss();
    test_sw_rst();
    test_sw_ignored();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
